mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus between instruction fetch (I port) and the data-transfer path (D port).
- The D port carries single LDR/STR transfers and the word-per-cycle stream from the load/store-multiple sequencer.
- One outstanding bus transaction at a time. Fixed D-over-I priority, with a starvation guard for fetch and a lock for uninterrupted LDM/STM bursts.
- Converts bus error and bus timeout into a per-requester abort pulse, for prefetch/data abort handling.

Parameters:
STARVE_MAX, 4, consecutive non-locked D grants allowed while I is pending before I is forced to win.
TIMEOUT, 255, bus_req-high cycles without ack/err before the transaction is aborted.

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
i_if_req  input  1  fetch request; held with address until o_if_ack or o_if_abort
i_if_addr  input  32  fetch word address
o_if_ack  output  1  one-cycle fetch completion pulse
o_if_rdata  output  32  fetch data, valid with o_if_ack
o_if_abort  output  1  one-cycle prefetch-abort pulse
i_dm_req  input  1  data request; fields held until o_dm_ack or o_dm_abort
i_dm_we  input  1  1=store, 0=load
i_dm_addr  input  32  data address
i_dm_wdata  input  32  store data
i_dm_be  input  4  byte enables
i_dm_lock  input  1  burst lock from the LDM/STM sequencer
o_dm_ack  output  1  one-cycle data completion pulse
o_dm_rdata  output  32  load data, valid with o_dm_ack
o_dm_abort  output  1  one-cycle data-abort pulse
o_bus_req  output  1  bus transaction valid
o_bus_we  output  1  registered write flag
o_bus_addr  output  32  registered address
o_bus_wdata  output  32  registered write data
o_bus_be  output  4  registered byte enables; 4'b1111 for fetch
o_bus_src  output  1  0=I, 1=D
i_bus_ack  input  1  transaction complete
i_bus_rdata  input  32  read data, valid with i_bus_ack
i_bus_err  input  1  bus error

Behaviour:
- **Reset:** synchronous on rst_n=0. State=IDLE; all outputs, starvation counter and timeout counter are 0. A reset mid-transaction drops the bus transaction silently; no ack or abort is issued.
- **States:** IDLE -> BUS -> RESP -> IDLE. Arbitration happens only in IDLE.
- **IDLE:**
  - No request: stay in IDLE.
  - Otherwise select a winner, register its fields into the o_bus_* registers, and go to BUS.
  - o_bus_req=1 from the next cycle onward.
- **Arbitration order:**
  1. i_dm_req & i_dm_lock: D wins. The starvation counter is unchanged.
  2. i_if_req & starve_cnt==STARVE_MAX: I wins.
  3. i_dm_req: D wins.
  4. i_if_req: I wins.
- **Starvation counter:**
  - Increments, saturating at STARVE_MAX, on each non-locked D grant made while i_if_req=1.
  - Clears on any I grant.
  - Holds otherwise.
- **BUS:**
  - o_bus_* are held stable.
  - Timeout counter starts at 0 on entry and increments each BUS cycle.
  - Transition to RESP on i_bus_ack, on i_bus_err, or when the counter reaches TIMEOUT-1 without ack/err (o_bus_req is high for exactly TIMEOUT cycles).
  - Outcome: err wins over ack in the same cycle; err and timeout both give outcome=abort.
  - i_bus_rdata is captured on ack.
- **RESP:**
  - o_bus_req=0.
  - Exactly one of o_x_ack / o_x_abort pulses for the granted source; o_x_rdata holds the captured data (0 on abort).
  - Next state is IDLE.
  - Requesters drop or advance their request in the RESP cycle. The stale request is never re-arbitrated because IDLE follows.
- **Latency:** request sampled at cycle 0 -> o_bus_req at cycle 1 -> ack at cycle 1+w -> o_x_ack at cycle 2+w -> next grant possible at cycle 3+w.
- **Rdata hold:** o_if_rdata and o_dm_rdata hold their last value outside RESP.
- **Ignored inputs:** i_bus_ack and i_bus_err are ignored outside BUS.
- **Request withdrawal:** a request deasserted while its transaction is in BUS does not cancel the transaction; completion is still reported.

Test Plan:
- **Single fetch:** i_if_req=1, addr 0x100, ack after 2 wait cycles with rdata 0xE3A00001 -> o_bus_req cycles 1-3, src=0, be=4'hF; o_if_ack=1 at cycle 4 with 0xE3A00001; IDLE at cycle 5.
- **Simultaneous requests:** both requesters at cycle 0, zero-wait acks -> first grant src=1 (D), then I; o_dm_ack precedes o_if_ack by 3 cycles.
- **Starvation:** both requests held high, lock=0, zero-wait acks -> grant sequence D,D,D,D,I,D,D,D,D,I.
- **Lock burst:** lock=1 for 6 D transfers with I pending and starve_cnt=4 -> 6 consecutive D grants; I granted first after lock drops.
- **Error and timeout:** a D store with i_bus_err=1 and i_bus_ack=1 in the same cycle -> o_dm_abort pulse only, no o_dm_ack. A fetch with no response -> o_bus_req high 255 cycles, then o_if_abort=1.
- **Reset mid-BUS:** rst_n=0 during a D transaction, ack arrives during reset -> all outputs 0 on the next clock, no ack or abort pulse; normal operation after release.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Memory bus arbiter: shares one bus between fetch (I) and data (D).
// One outstanding transaction; D priority with starvation guard and lock.
module mem_bus_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_if_req,
   input  logic [31:0] i_if_addr,
   output logic        o_if_ack,
   output logic [31:0] o_if_rdata,
   output logic        o_if_abort,
   input  logic        i_dm_req,
   input  logic        i_dm_we,
   input  logic [31:0] i_dm_addr,
   input  logic [31:0] i_dm_wdata,
   input  logic [3:0]  i_dm_be,
   input  logic        i_dm_lock,
   output logic        o_dm_ack,
   output logic [31:0] o_dm_rdata,
   output logic        o_dm_abort,
   output logic        o_bus_req,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   output logic        o_bus_src,
   input  logic        i_bus_ack,
   input  logic [31:0] i_bus_rdata,
   input  logic        i_bus_err
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          bus_req_q, bus_req_d;
   logic          bus_we_q, bus_we_d;
   logic [31:0]   bus_addr_q, bus_addr_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;
   logic [3:0]    bus_be_q, bus_be_d;
   logic          bus_src_q, bus_src_d;
   logic          if_ack_q, if_ack_d;
   logic          if_abort_q, if_abort_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic          dm_ack_q, dm_ack_d;
   logic          dm_abort_q, dm_abort_d;
   logic [31:0]   dm_rdata_q, dm_rdata_d;

   logic          starved;
   logic          d_win;
   logic          i_win;
   logic          done;
   logic          ok;

   // Arbitration, bus sequencing and completion reporting
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_be_d    = bus_be_q;
      bus_src_d   = bus_src_q;
      if_ack_d    = 1'b0;
      if_abort_d  = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_ack_d    = 1'b0;
      dm_abort_d  = 1'b0;
      dm_rdata_d  = dm_rdata_q;

      starved = i_if_req && (starve_q == SW'(STARVE_MAX));
      d_win   = i_dm_req && (i_dm_lock || !starved);
      i_win   = i_if_req && !d_win;
      done    = i_bus_ack || i_bus_err ||
                (tmo_q == TW'(TIMEOUT - 1));
      ok      = i_bus_ack && !i_bus_err;

      unique case (state_q)
         S_IDLE: begin
            if (d_win) begin
               state_d     = S_BUS;
               tmo_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = i_dm_we;
               bus_addr_d  = i_dm_addr;
               bus_wdata_d = i_dm_wdata;
               bus_be_d    = i_dm_be;
               bus_src_d   = 1'b1;
               // locked bursts do not count against fetch
               if (!i_dm_lock && i_if_req &&
                   starve_q != SW'(STARVE_MAX))
                  starve_d = starve_q + SW'(1);
            end else if (i_win) begin
               state_d     = S_BUS;
               tmo_d       = '0;
               bus_req_d   = 1'b1;
               bus_we_d    = 1'b0;
               bus_addr_d  = i_if_addr;
               bus_wdata_d = '0;
               bus_be_d    = 4'hF;
               bus_src_d   = 1'b0;
               starve_d    = '0;
            end
         end
         S_BUS: begin
            tmo_d = tmo_q + TW'(1);
            if (done) begin
               state_d   = S_RESP;
               bus_req_d = 1'b0;
               // err beats ack; timeout also aborts
               if (bus_src_q) begin
                  dm_ack_d   = ok;
                  dm_abort_d = !ok;
                  dm_rdata_d = ok ? i_bus_rdata : '0;
               end else begin
                  if_ack_d   = ok;
                  if_abort_d = !ok;
                  if_rdata_d = ok ? i_bus_rdata : '0;
               end
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_be_q    <= '0;
         bus_src_q   <= 1'b0;
         if_ack_q    <= 1'b0;
         if_abort_q  <= 1'b0;
         if_rdata_q  <= '0;
         dm_ack_q    <= 1'b0;
         dm_abort_q  <= 1'b0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_be_q    <= bus_be_d;
         bus_src_q   <= bus_src_d;
         if_ack_q    <= if_ack_d;
         if_abort_q  <= if_abort_d;
         if_rdata_q  <= if_rdata_d;
         dm_ack_q    <= dm_ack_d;
         dm_abort_q  <= dm_abort_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign o_bus_req   = bus_req_q;
   assign o_bus_we    = bus_we_q;
   assign o_bus_addr  = bus_addr_q;
   assign o_bus_wdata = bus_wdata_q;
   assign o_bus_be    = bus_be_q;
   assign o_bus_src   = bus_src_q;
   assign o_if_ack    = if_ack_q;
   assign o_if_abort  = if_abort_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_dm_ack    = dm_ack_q;
   assign o_dm_abort  = dm_abort_q;
   assign o_dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table plus directed
// sequences for starvation, lock, timeout and reset.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_if_req;
   logic [31:0] i_if_addr;
   logic        o_if_ack;
   logic [31:0] o_if_rdata;
   logic        o_if_abort;
   logic        i_dm_req;
   logic        i_dm_we;
   logic [31:0] i_dm_addr;
   logic [31:0] i_dm_wdata;
   logic [3:0]  i_dm_be;
   logic        i_dm_lock;
   logic        o_dm_ack;
   logic [31:0] o_dm_rdata;
   logic        o_dm_abort;
   logic        o_bus_req;
   logic        o_bus_we;
   logic [31:0] o_bus_addr;
   logic [31:0] o_bus_wdata;
   logic [3:0]  o_bus_be;
   logic        o_bus_src;
   logic        i_bus_ack;
   logic [31:0] i_bus_rdata;
   logic        i_bus_err;

   int checks = 0;
   int fails  = 0;

   mem_bus_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .i_if_req(i_if_req), .i_if_addr(i_if_addr),
      .o_if_ack(o_if_ack), .o_if_rdata(o_if_rdata),
      .o_if_abort(o_if_abort),
      .i_dm_req(i_dm_req), .i_dm_we(i_dm_we),
      .i_dm_addr(i_dm_addr), .i_dm_wdata(i_dm_wdata),
      .i_dm_be(i_dm_be), .i_dm_lock(i_dm_lock),
      .o_dm_ack(o_dm_ack), .o_dm_rdata(o_dm_rdata),
      .o_dm_abort(o_dm_abort),
      .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
      .o_bus_be(o_bus_be), .o_bus_src(o_bus_src),
      .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata),
      .i_bus_err(i_bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic [3:0]  dm_be;
      logic        ack;
      logic        err;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_src;
      logic        e_we;
      logic [31:0] e_addr;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
      logic [3:0]  e_pulse;
      logic [31:0] e_if_rd;
      logic [31:0] e_dm_rd;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_inputs();
      i_if_req    = 1'b0;
      i_if_addr   = '0;
      i_dm_req    = 1'b0;
      i_dm_we     = 1'b0;
      i_dm_addr   = '0;
      i_dm_wdata  = '0;
      i_dm_be     = '0;
      i_dm_lock   = 1'b0;
      i_bus_ack   = 1'b0;
      i_bus_rdata = '0;
      i_bus_err   = 1'b0;
   endtask

   task automatic do_reset();
      clr_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   function automatic logic [3:0] pulses();
      return {o_if_ack, o_if_abort, o_dm_ack, o_dm_abort};
   endfunction

   task automatic check(input string name,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Wait for a grant, ack it, check the completion pulse.
   task automatic serve(input string name, output logic src);
      int n;
      logic [31:0] rd;
      n = 0;
      while (!o_bus_req && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!o_bus_req) begin
         fails++;
         $display("FAIL %s_wait got=timeout exp=grant", name);
         src = 1'bx;
         return;
      end
      src = o_bus_src;
      rd = $urandom;
      i_bus_ack   = 1'b1;
      i_bus_rdata = rd;
      tick();
      i_bus_ack   = 1'b0;
      if (src)
         check({name, "_resp"}, {pulses(), o_dm_rdata},
               {4'b0010, rd});
      else
         check({name, "_resp"}, {pulses(), o_if_rdata},
               {4'b1000, rd});
   endtask

   task automatic add(input logic ir, input logic [31:0] ia,
                      input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dd,
                      input logic [3:0] db, input logic ak,
                      input logic er, input logic [31:0] rd,
                      input logic eq, input logic es,
                      input logic ew, input logic [31:0] ea,
                      input logic [31:0] ed, input logic [3:0] eb,
                      input logic [3:0] ep, input logic [31:0] eir,
                      input logic [31:0] edr);
      vec_t v;
      v = '{ir, ia, dr, dw, da, dd, db, ak, er, rd,
            eq, es, ew, ea, ed, eb, ep, eir, edr};
      tbl.push_back(v);
   endtask

   localparam logic [31:0] F1 = 32'hE3A00001;
   localparam logic [31:0] D1 = 32'h11111111;
   localparam logic [31:0] F2 = 32'h22222222;

   logic src;
   logic exp_src[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
   int   n;

   initial begin
      // single fetch, 2 wait states
      add(1,'h100,0,0,0,0,0,0,0,0, 1,0,0,'h100,0,4'hF,0,0,0);
      add(1,'h100,0,0,0,0,0,0,0,0, 1,0,0,'h100,0,4'hF,0,0,0);
      add(1,'h100,0,0,0,0,0,0,0,0, 1,0,0,'h100,0,4'hF,0,0,0);
      add(1,'h100,0,0,0,0,0,1,0,F1, 0,0,0,0,0,0,4'b1000,F1,0);
      add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,F1,0);
      add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,F1,0);
      // simultaneous: D first, then I three cycles later
      add(1,'h200,1,0,'h400,0,4'h3,0,0,0,
          1,1,0,'h400,0,4'h3,0,F1,0);
      add(1,'h200,1,0,'h400,0,4'h3,1,0,D1,
          0,0,0,0,0,0,4'b0010,F1,D1);
      add(1,'h200,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,F1,D1);
      add(1,'h200,0,0,0,0,0,0,0,0,
          1,0,0,'h200,0,4'hF,0,F1,D1);
      add(1,'h200,0,0,0,0,0,1,0,F2,
          0,0,0,0,0,0,4'b1000,F2,D1);
      add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,F2,D1);
      // store with err+ack together: abort only
      add(0,0,1,1,'h800,'hDEADBEEF,4'hF,0,0,0,
          1,1,1,'h800,'hDEADBEEF,4'hF,0,F2,D1);
      add(0,0,1,1,'h800,'hDEADBEEF,4'hF,1,1,'h55,
          0,0,0,0,0,0,4'b0001,F2,0);
      add(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,F2,0);
      // ack/err outside BUS ignored
      add(0,0,0,0,0,0,0,1,1,'h77, 0,0,0,0,0,0,0,F2,0);

      clr_inputs();
      rst_n = 1'b0;
      tick();
      tick();
      check("reset_ctl",
            {o_bus_req, o_bus_we, o_bus_src, o_bus_be, pulses()},
            '0);
      check("reset_data", {o_bus_addr, o_bus_wdata}, '0);
      check("reset_rdata", {o_if_rdata, o_dm_rdata}, '0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         i_if_req    = tbl[i].if_req;
         i_if_addr   = tbl[i].if_addr;
         i_dm_req    = tbl[i].dm_req;
         i_dm_we     = tbl[i].dm_we;
         i_dm_addr   = tbl[i].dm_addr;
         i_dm_wdata  = tbl[i].dm_wdata;
         i_dm_be     = tbl[i].dm_be;
         i_bus_ack   = tbl[i].ack;
         i_bus_err   = tbl[i].err;
         i_bus_rdata = tbl[i].rdata;
         tick();
         check($sformatf("vec%0d_ctl", i),
               {o_bus_req, pulses(), o_if_rdata, o_dm_rdata},
               {tbl[i].e_req, tbl[i].e_pulse,
                tbl[i].e_if_rd, tbl[i].e_dm_rd});
         if (tbl[i].e_req) begin
            check($sformatf("vec%0d_bus", i),
                  {o_bus_src, o_bus_we, o_bus_be, o_bus_addr},
                  {tbl[i].e_src, tbl[i].e_we, tbl[i].e_be,
                   tbl[i].e_addr});
            check($sformatf("vec%0d_wdata", i),
                  {32'h0, o_bus_wdata}, {32'h0, tbl[i].e_wdata});
         end
      end

      // starvation guard
      do_reset();
      i_if_req  = 1'b1;
      i_if_addr = 32'h1000;
      i_dm_req  = 1'b1;
      i_dm_addr = 32'h2000;
      i_dm_be   = 4'hF;
      for (int g = 0; g < 10; g++) begin
         serve($sformatf("starve%0d", g), src);
         check($sformatf("starve%0d_src", g),
               {63'h0, src}, {63'h0, exp_src[g]});
      end

      // lock burst with starve counter already saturated
      do_reset();
      i_if_req  = 1'b1;
      i_dm_req  = 1'b1;
      i_dm_be   = 4'hF;
      for (int g = 0; g < 4; g++) begin
         serve($sformatf("pre%0d", g), src);
         check($sformatf("pre%0d_src", g),
               {63'h0, src}, 64'h1);
      end
      i_dm_lock = 1'b1;
      for (int g = 0; g < 6; g++) begin
         serve($sformatf("lock%0d", g), src);
         check($sformatf("lock%0d_src", g),
               {63'h0, src}, 64'h1);
      end
      i_dm_lock = 1'b0;
      serve("unlock", src);
      check("unlock_src", {63'h0, src}, 64'h0);

      // fetch timeout
      do_reset();
      i_if_req  = 1'b1;
      i_if_addr = 32'h300;
      tick();
      n = 0;
      while (o_bus_req && n < 300) begin
         n++;
         tick();
      end
      check("tmo_cycles", 64'(n), 64'd255);
      check("tmo_abort", {pulses(), o_if_rdata},
            {4'b0100, 32'h0});
      i_if_req = 1'b0;
      tick();
      check("tmo_pulse_len", {60'h0, pulses()}, 64'h0);

      // reset during BUS drops the transaction
      do_reset();
      i_dm_req  = 1'b1;
      i_dm_addr = 32'h900;
      i_dm_be   = 4'hF;
      tick();
      check("rst_bus", {62'h0, o_bus_req, o_bus_src}, 64'h3);
      rst_n     = 1'b0;
      i_bus_ack = 1'b1;
      i_bus_rdata = 32'hABCD;
      tick();
      check("rst_mid",
            {o_bus_req, o_bus_src, o_bus_we, pulses(),
             o_dm_rdata, o_bus_be}, '0);
      check("rst_mid_addr", {32'h0, o_bus_addr}, '0);
      rst_n     = 1'b1;
      i_bus_ack = 1'b0;
      i_dm_req  = 1'b0;
      tick();
      check("rst_after", {59'h0, o_bus_req, pulses()}, '0);
      i_dm_req = 1'b1;
      serve("rst_resume", src);
      check("rst_resume_src", {63'h0, src}, 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
